// File: rtl/debounce_multi.sv
// N-channel button debouncer: two-flop synchroniser, shared 1 ms prescaler, debounced level,
// press/release edge pulses, long-press detection and optional auto-repeat.
module debounce_multi #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned N_CH        = 4,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 500,
  parameter int unsigned REPEAT_MS   = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] button_db,
  output logic [N_CH-1:0] button_rising,
  output logic [N_CH-1:0] button_falling,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] button_repeat
);

  localparam int unsigned PRE_DIV  = CLK_FREQ_HZ / 1000;
  localparam int unsigned PRE_W    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int unsigned DCNT_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int unsigned HCNT_W   = $clog2(HOLD_MAX + 1);
  localparam int unsigned REP_LAST = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;

  typedef enum logic [1:0] {
    WAIT_LONG = 2'd0,
    REPEATING = 2'd1,
    DONE      = 2'd2
  } phase_t;

  logic [N_CH-1:0]   r_sync1;
  logic [N_CH-1:0]   r_sync2;
  logic [N_CH-1:0]   r_db;
  logic [N_CH-1:0]   r_rise;
  logic [N_CH-1:0]   r_fall;
  logic [N_CH-1:0]   r_long;
  logic [N_CH-1:0]   r_rep;
  logic [PRE_W-1:0]  r_pre;
  logic [DCNT_W-1:0] r_dcnt  [N_CH];
  logic [HCNT_W-1:0] r_hcnt  [N_CH];
  phase_t            r_phase [N_CH];

  logic [N_CH-1:0]   w_s;
  logic              w_tick;
  logic [PRE_W-1:0]  w_pre_nxt;
  logic [N_CH-1:0]   w_db_nxt;
  logic [N_CH-1:0]   w_rise_nxt;
  logic [N_CH-1:0]   w_fall_nxt;
  logic [N_CH-1:0]   w_long_nxt;
  logic [N_CH-1:0]   w_rep_nxt;
  logic [DCNT_W-1:0] w_dcnt_nxt  [N_CH];
  logic [HCNT_W-1:0] w_hcnt_nxt  [N_CH];
  phase_t            w_phase_nxt [N_CH];

  // Synchronised level with polarity folded in: 1 = pressed
  assign w_s    = r_sync2 ^ {N_CH{ACTIVE_LOW}};
  assign w_tick = (r_pre == PRE_W'(PRE_DIV - 1));

  always_comb begin
    w_pre_nxt  = w_tick ? '0 : r_pre + PRE_W'(1);
    w_db_nxt   = r_db;
    w_long_nxt = '0;
    w_rep_nxt  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_dcnt_nxt[i]  = r_dcnt[i];
      w_hcnt_nxt[i]  = r_hcnt[i];
      w_phase_nxt[i] = r_phase[i];
    end

    for (int i = 0; i < N_CH; i++) begin
      // Debounce: any agreement clears the count, disagreement only advances on ticks
      if (w_s[i] == r_db[i]) begin
        w_dcnt_nxt[i] = '0;
      end else if (w_tick) begin
        if (r_dcnt[i] == DCNT_W'(DEBOUNCE_MS - 1)) begin
          w_db_nxt[i]   = w_s[i];
          w_dcnt_nxt[i] = '0;
        end else begin
          w_dcnt_nxt[i] = r_dcnt[i] + DCNT_W'(1);
        end
      end

      // Hold timing keys off the next debounced level so a release wins over a completing tick
      if (!w_db_nxt[i]) begin
        w_hcnt_nxt[i]  = '0;
        w_phase_nxt[i] = WAIT_LONG;
      end else if (r_db[i] && w_tick) begin
        case (r_phase[i])
          WAIT_LONG: begin
            if (r_hcnt[i] == HCNT_W'(LONG_MS - 1)) begin
              w_long_nxt[i]  = 1'b1;
              w_hcnt_nxt[i]  = '0;
              w_phase_nxt[i] = (REPEAT_MS != 0) ? REPEATING : DONE;
            end else begin
              w_hcnt_nxt[i] = r_hcnt[i] + HCNT_W'(1);
            end
          end
          REPEATING: begin
            if (r_hcnt[i] == HCNT_W'(REP_LAST)) begin
              w_rep_nxt[i]  = 1'b1;
              w_hcnt_nxt[i] = '0;
            end else begin
              w_hcnt_nxt[i] = r_hcnt[i] + HCNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end

    w_rise_nxt = w_db_nxt & ~r_db;
    w_fall_nxt = ~w_db_nxt & r_db;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= {N_CH{ACTIVE_LOW}};
      r_sync2 <= {N_CH{ACTIVE_LOW}};
      r_db    <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_long  <= '0;
      r_rep   <= '0;
      r_pre   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_dcnt[i]  <= '0;
        r_hcnt[i]  <= '0;
        r_phase[i] <= WAIT_LONG;
      end
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      r_db    <= w_db_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_long  <= w_long_nxt;
      r_rep   <= w_rep_nxt;
      r_pre   <= w_pre_nxt;
      for (int i = 0; i < N_CH; i++) begin
        r_dcnt[i]  <= w_dcnt_nxt[i];
        r_hcnt[i]  <= w_hcnt_nxt[i];
        r_phase[i] <= w_phase_nxt[i];
      end
    end
  end

  assign button_db      = r_db;
  assign button_rising  = r_rise;
  assign button_falling = r_fall;
  assign long_press     = r_long;
  assign button_repeat  = r_rep;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (repeat on / repeat off) checked every cycle against a
// tick-counting reference model, plus directed timing checks on the scenarios of interest.
module tb_debounce_multi;

  localparam int CLK_HZ = 10_000;
  localparam int NCH    = 2;
  localparam int DEB    = 3;
  localparam int LNG    = 8;
  localparam int REP    = 4;
  localparam int TPM    = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] button;
  logic [1:0] db0, rise0, fall0, long0, rep0;
  logic [1:0] db1, rise1, fall1, long1, rep1;

  always #5 clk = ~clk;

  debounce_multi #(
    .CLK_FREQ_HZ(CLK_HZ), .N_CH(NCH), .ACTIVE_LOW(1'b1),
    .DEBOUNCE_MS(DEB), .LONG_MS(LNG), .REPEAT_MS(REP)
  ) u_dut (
    .clk(clk), .rst(rst), .button(button),
    .button_db(db0), .button_rising(rise0), .button_falling(fall0),
    .long_press(long0), .button_repeat(rep0)
  );

  debounce_multi #(
    .CLK_FREQ_HZ(CLK_HZ), .N_CH(NCH), .ACTIVE_LOW(1'b1),
    .DEBOUNCE_MS(DEB), .LONG_MS(LNG), .REPEAT_MS(0)
  ) u_dut_norep (
    .clk(clk), .rst(rst), .button(button),
    .button_db(db1), .button_rising(rise1), .button_falling(fall1),
    .long_press(long1), .button_repeat(rep1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Reference model: counts ticks of continuous disagreement and ticks of continuous hold
  int         m_cyc;
  logic [1:0] m_p1, m_p2;
  logic [1:0] m_db [2];
  logic [1:0] m_rise [2];
  logic [1:0] m_fall [2];
  logic [1:0] m_long [2];
  logic [1:0] m_rep [2];
  int         m_dis [2][2];
  int         m_held [2][2];
  logic       m_tick, m_nd, m_pr;
  int         m_rp;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cyc = 0;
      m_p1  = 2'b11;
      m_p2  = 2'b11;
      for (int d = 0; d < 2; d++) begin
        m_db[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_long[d] = '0; m_rep[d] = '0;
        for (int c = 0; c < 2; c++) begin
          m_dis[d][c]  = 0;
          m_held[d][c] = 0;
        end
      end
    end else begin
      m_tick = ((m_cyc % TPM) == TPM - 1);
      for (int d = 0; d < 2; d++) begin
        m_rp = (d == 0) ? REP : 0;
        for (int c = 0; c < 2; c++) begin
          m_nd = m_db[d][c];
          m_pr = ~m_p2[c];
          if (m_pr != m_nd) begin
            if (m_tick) begin
              m_dis[d][c]++;
              if (m_dis[d][c] == DEB) begin
                m_nd        = m_pr;
                m_dis[d][c] = 0;
              end
            end
          end else begin
            m_dis[d][c] = 0;
          end
          m_rise[d][c] = m_nd & ~m_db[d][c];
          m_fall[d][c] = ~m_nd & m_db[d][c];
          m_long[d][c] = 1'b0;
          m_rep[d][c]  = 1'b0;
          if (!m_nd) begin
            m_held[d][c] = 0;
          end else if (m_db[d][c] && m_tick) begin
            m_held[d][c]++;
            m_long[d][c] = (m_held[d][c] == LNG);
            m_rep[d][c]  = (m_rp != 0) && (m_held[d][c] > LNG) && (((m_held[d][c] - LNG) % m_rp) == 0);
          end
          m_db[d][c] = m_nd;
        end
      end
      m_p2 = m_p1;
      m_p1 = button;
      m_cyc++;
    end
  end

  // Every-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("outs_rep",   32'({db0, rise0, fall0, long0, rep0}),
                          32'({m_db[0], m_rise[0], m_fall[0], m_long[0], m_rep[0]}));
      check("outs_norep", 32'({db1, rise1, fall1, long1, rep1}),
                          32'({m_db[1], m_rise[1], m_fall[1], m_long[1], m_rep[1]}));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  int lat, lat1, t_long, t_prev, n_long, n_rep, n_long_nr, n_rep_nr, n_fall, n_evt, k;

  initial begin
    rst    = 1'b1;
    button = 2'b11;
    repeat (3) step();
    check("reset_outputs", 32'({db0, rise0, fall0, long0, rep0, db1, rise1, fall1, long1, rep1}), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Clean press on ch0 at a random prescaler phase
    repeat ($urandom_range(0, 9)) step();
    button[0] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (db0[0]) begin lat = i; break; end
    end
    check("press_latency_in_22_33", 32'(lat >= 22 && lat <= 33), 32'd1);
    check("rise_aligned", 32'(rise0[0]), 32'd1);
    check("ch1_idle", 32'(db0[1]), 32'd0);
    step();
    check("rise_one_cycle", 32'(rise0[0]), 32'd0);

    // Hold 200 cycles after the rise: long press then periodic repeat
    t_long = -1; t_prev = -1; n_long = 0; n_rep = 0; n_long_nr = 0; n_rep_nr = 0;
    for (int i = 2; i <= 200; i++) begin
      step();
      if (long0[0]) begin n_long++; t_long = i; end
      if (rep0[0]) begin
        if (t_prev < 0) check("first_repeat_gap", 32'(i - t_long), 32'd40);
        else            check("repeat_period", 32'(i - t_prev), 32'd40);
        t_prev = i;
        n_rep++;
      end
      if (long1[0]) n_long_nr++;
      if (rep1[0])  n_rep_nr++;
    end
    check("long_count", 32'(n_long), 32'd1);
    check("long_delay_80pm10", 32'(t_long >= 70 && t_long <= 90), 32'd1);
    check("repeat_count", 32'(n_rep), 32'd3);
    check("norep_long_count", 32'(n_long_nr), 32'd1);
    check("norep_repeat_count", 32'(n_rep_nr), 32'd0);

    // Release: one falling pulse, repeats stop
    button[0] = 1'b1;
    n_fall = 0; n_rep = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (fall0[0]) n_fall++;
      if (rep0[0] || long0[0]) n_rep++;
    end
    check("release_fall_count", 32'(n_fall), 32'd1);
    check("release_no_repeat", 32'(n_rep), 32'd0);
    check("release_db", 32'(db0[0]), 32'd0);

    // Bounce train: low stretches under 2 ms never reach three disagreeing ticks
    n_evt = 0;
    for (int b = 0; b < 5; b++) begin
      button[0] = 1'b0;
      k = $urandom_range(5, 19);
      for (int i = 0; i < k; i++) begin
        step();
        if (db0[0] | rise0[0] | fall0[0] | long0[0] | rep0[0]) n_evt++;
      end
      button[0] = 1'b1;
      k = $urandom_range(5, 20);
      for (int i = 0; i < k; i++) begin
        step();
        if (db0[0] | rise0[0] | fall0[0] | long0[0] | rep0[0]) n_evt++;
      end
    end
    for (int i = 0; i < 30; i++) begin
      step();
      if (db0[0] | rise0[0] | fall0[0] | long0[0] | rep0[0]) n_evt++;
    end
    check("bounce_rejected", 32'(n_evt), 32'd0);

    // Simultaneous press on both channels, then release ch1 only
    repeat ($urandom_range(0, 9)) step();
    button = 2'b00;
    lat = -1; lat1 = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (db0[0] && lat < 0)  lat = i;
      if (db0[1] && lat1 < 0) lat1 = i;
      if (lat >= 0 && lat1 >= 0) break;
    end
    check("simul_same_timing", 32'(lat1), 32'(lat));
    check("simul_both_rise", 32'(rise0), 32'd3);
    repeat (130) step();
    button[1] = 1'b1;
    t_prev = -1; n_rep = 0; n_fall = 0;
    for (int i = 1; i <= 120; i++) begin
      step();
      if (fall0[1]) n_fall++;
      if (rep0[0]) begin
        if (t_prev >= 0) check("ch0_period_undisturbed", 32'(i - t_prev), 32'd40);
        t_prev = i;
        n_rep++;
      end
    end
    check("ch1_fall_count", 32'(n_fall), 32'd1);
    check("ch0_still_repeating", 32'(n_rep >= 2), 32'd1);
    button = 2'b11;
    repeat (60) step();

    // Reset while ch0 is repeating with the pin still low
    button[0] = 1'b0;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (rep0[0]) begin k = 1; break; end
    end
    check("reached_repeating", 32'(k), 32'd1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_reset_outputs", 32'({db0, rise0, fall0, long0, rep0, db1, rise1, fall1, long1, rep1}), 32'd0);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (db0[0]) begin lat = i; break; end
    end
    check("rerise_about_30", 32'(lat >= 25 && lat <= 33), 32'd1);
    check("rerise_fresh_pulse", 32'(rise0[0]), 32'd1);
    t_long = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (long0[0]) begin t_long = i; break; end
    end
    check("relong_80pm10", 32'(t_long >= 70 && t_long <= 90), 32'd1);
    button = 2'b11;
    repeat (60) step();

    // Random pin activity on both channels, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 29) == 0) button[c] = ~button[c];
      step();
    end
    button = 2'b11;
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
